rf_wb_arbiter: RTL and testbench

- Writeback stage directly upstream of the 3-read/2-write core register file. Drives both RF write ports and tracks outstanding loads.
- EX port-A results (ALU) go to write port W1.
- EX port-B results (post-increment address update) and out-of-order LSU load responses share write port W2. EX-B has priority; LSU data is buffered in a small FIFO with valid/ready backpressure.
- A pending-load scoreboard flags hazards on the three RF read addresses and on the EX destinations.

---
 rtl/rf_wb_pkg.sv | 22 ++
 rtl/rf_wb_fifo.sv | 57 +++++
 rtl/rf_wb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef enum logic {
    WB_SRC_EX,
    WB_SRC_LSU
  } wb_src_e;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] waddr;
    logic [RF_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  // Count needs one extra bit so that "full" is distinguishable from "empty".
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular-buffer FIFO for LSU load responses; full/empty come from registered state only.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_req_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_width(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback stage: drives both RF write ports, arbitrates EX-B vs buffered LSU data on W2,
// and keeps a pending-load scoreboard for hazard detection.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 2,
  parameter bit ZERO_REG_WE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_a_valid_i,
  input  logic [ADDR_WIDTH-1:0]      ex_a_waddr_i,
  input  logic [DATA_WIDTH-1:0]      ex_a_wdata_i,
  input  logic                       ex_b_valid_i,
  input  logic [ADDR_WIDTH-1:0]      ex_b_waddr_i,
  input  logic [DATA_WIDTH-1:0]      ex_b_wdata_i,
  input  logic                       ld_issue_i,
  input  logic [ADDR_WIDTH-1:0]      ld_issue_addr_i,
  input  logic                       lsu_valid_i,
  output logic                       lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]      lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]      raddr_c_i,
  output logic [ADDR_WIDTH-1:0]      waddr_a_o,
  output logic [DATA_WIDTH-1:0]      wdata_a_o,
  output logic                       we_a_o,
  output logic [ADDR_WIDTH-1:0]      waddr_b_o,
  output logic [DATA_WIDTH-1:0]      wdata_b_o,
  output logic                       we_b_o,
  output logic [(2**ADDR_WIDTH)-1:0] pending_o,
  output logic                       hazard_o
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  // FIFO entries use the shared wb_req_t layout, whose widths are fixed in the package.
  if (ADDR_WIDTH != RF_ADDR_WIDTH || DATA_WIDTH != RF_DATA_WIDTH) begin : g_width_check
    $error("rf_wb_arbiter: ADDR_WIDTH/DATA_WIDTH must match rf_wb_pkg widths");
  end

  function automatic logic wr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return ZERO_REG_WE || (addr != '0);
  endfunction

  logic                  we_a_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q;
  logic [DATA_WIDTH-1:0] wdata_a_q;

  logic                  we_b_q,    we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_b_q, wdata_b_d;
  wb_src_e               src_q,     src_d;

  logic [NUM_WORDS-1:0]  pending_q, pending_d;

  wb_req_t lsu_req;
  wb_req_t fifo_head;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_push;
  logic    fifo_pop;

  // W1: ALU results, one-cycle latency; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
    end else begin
      we_a_q <= ex_a_valid_i && wr_ok(ex_a_waddr_i);
      if (ex_a_valid_i) begin
        waddr_a_q <= ex_a_waddr_i;
        wdata_a_q <= ex_a_wdata_i;
      end
    end
  end

  assign lsu_req     = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
  assign lsu_ready_o = !fifo_full;
  assign fifo_push   = lsu_valid_i && !fifo_full;
  assign fifo_pop    = !ex_b_valid_i && !fifo_empty;

  rf_wb_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (wb_req_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (lsu_req),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // W2: EX-B always wins; the LSU head drains only in cycles EX-B leaves free.
  always_comb begin
    we_b_d    = 1'b0;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    src_d     = src_q;
    if (ex_b_valid_i) begin
      we_b_d    = wr_ok(ex_b_waddr_i);
      waddr_b_d = ex_b_waddr_i;
      wdata_b_d = ex_b_wdata_i;
      src_d     = WB_SRC_EX;
    end else if (!fifo_empty) begin
      we_b_d    = wr_ok(fifo_head.waddr);
      waddr_b_d = fifo_head.waddr;
      wdata_b_d = fifo_head.wdata;
      src_d     = WB_SRC_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      src_q     <= WB_SRC_EX;
    end else begin
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      src_q     <= src_d;
    end
  end

  // Set is applied after clear so a newly issued load to the same register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (we_b_q && (src_q == WB_SRC_LSU)) begin
      pending_d[waddr_b_q] = 1'b0;
    end
    if (ld_issue_i && wr_ok(ld_issue_addr_i)) begin
      pending_d[ld_issue_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign hazard_o = pending_q[raddr_a_i] | pending_q[raddr_b_i] | pending_q[raddr_c_i]
                  | (ex_a_valid_i & pending_q[ex_a_waddr_i])
                  | (ex_b_valid_i & pending_q[ex_b_waddr_i]);

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ex_a_valid_i;
  logic [4:0]  ex_a_waddr_i;
  logic [31:0] ex_a_wdata_i;
  logic        ex_b_valid_i;
  logic [4:0]  ex_b_waddr_i;
  logic [31:0] ex_b_wdata_i;
  logic        ld_issue_i;
  logic [4:0]  ld_issue_addr_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic [4:0]  raddr_c_i;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_a_o;
  logic [4:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        we_b_o;
  logic [31:0] pending_o;
  logic        hazard_o;

  int n_checks = 0;
  int n_errors = 0;

  rf_wb_arbiter #(
    .ADDR_WIDTH  (5),
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (2),
    .ZERO_REG_WE (1'b0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_a_valid_i    (ex_a_valid_i),
    .ex_a_waddr_i    (ex_a_waddr_i),
    .ex_a_wdata_i    (ex_a_wdata_i),
    .ex_b_valid_i    (ex_b_valid_i),
    .ex_b_waddr_i    (ex_b_waddr_i),
    .ex_b_wdata_i    (ex_b_wdata_i),
    .ld_issue_i      (ld_issue_i),
    .ld_issue_addr_i (ld_issue_addr_i),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_ready_o     (lsu_ready_o),
    .lsu_waddr_i     (lsu_waddr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .raddr_a_i       (raddr_a_i),
    .raddr_b_i       (raddr_b_i),
    .raddr_c_i       (raddr_c_i),
    .waddr_a_o       (waddr_a_o),
    .wdata_a_o       (wdata_a_o),
    .we_a_o          (we_a_o),
    .waddr_b_o       (waddr_b_o),
    .wdata_b_o       (wdata_b_o),
    .we_b_o          (we_b_o),
    .pending_o       (pending_o),
    .hazard_o        (hazard_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs driven in a cycle, and the outputs expected in that same cycle.
  typedef struct {
    logic        ea_v; logic [4:0] ea_a; logic [31:0] ea_d;
    logic        eb_v; logic [4:0] eb_a; logic [31:0] eb_d;
    logic        ld_v; logic [4:0] ld_a;
    logic        ls_v; logic [4:0] ls_a; logic [31:0] ls_d;
    logic [4:0]  ra;   logic [4:0] rb;   logic [4:0]  rc;
    logic        x_we_a; logic [4:0] x_wa_a; logic [31:0] x_wd_a;
    logic        x_we_b; logic [4:0] x_wa_b; logic [31:0] x_wd_b;
    logic        x_rdy;  logic [31:0] x_pend; logic x_haz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_a_valid_i = 1'b0; ex_a_waddr_i = 5'd0; ex_a_wdata_i = 32'h0;
    ex_b_valid_i = 1'b0; ex_b_waddr_i = 5'd0; ex_b_wdata_i = 32'h0;
    ld_issue_i = 1'b0; ld_issue_addr_i = 5'd0;
    lsu_valid_i = 1'b0; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'h0;
    raddr_a_i = 5'd0; raddr_b_i = 5'd0; raddr_c_i = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    ex_a_valid_i = v.ea_v; ex_a_waddr_i = v.ea_a; ex_a_wdata_i = v.ea_d;
    ex_b_valid_i = v.eb_v; ex_b_waddr_i = v.eb_a; ex_b_wdata_i = v.eb_d;
    ld_issue_i = v.ld_v; ld_issue_addr_i = v.ld_a;
    lsu_valid_i = v.ls_v; lsu_waddr_i = v.ls_a; lsu_wdata_i = v.ls_d;
    raddr_a_i = v.ra; raddr_b_i = v.rb; raddr_c_i = v.rc;
  endtask

  task automatic compare(input int i, input vec_t v);
    chk($sformatf("r%0d.we_a", i),    64'(we_a_o),      64'(v.x_we_a));
    chk($sformatf("r%0d.waddr_a", i), 64'(waddr_a_o),   64'(v.x_wa_a));
    chk($sformatf("r%0d.wdata_a", i), 64'(wdata_a_o),   64'(v.x_wd_a));
    chk($sformatf("r%0d.we_b", i),    64'(we_b_o),      64'(v.x_we_b));
    chk($sformatf("r%0d.waddr_b", i), 64'(waddr_b_o),   64'(v.x_wa_b));
    chk($sformatf("r%0d.wdata_b", i), 64'(wdata_b_o),   64'(v.x_wd_b));
    chk($sformatf("r%0d.ready", i),   64'(lsu_ready_o), 64'(v.x_rdy));
    chk($sformatf("r%0d.pending", i), 64'(pending_o),   64'(v.x_pend));
    chk($sformatf("r%0d.hazard", i),  64'(hazard_o),    64'(v.x_haz));
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] P5 = 32'h0000_0020;

  initial begin
    // ea(v,a,d) eb(v,a,d) ld(v,a) lsu(v,a,d) ra rb rc | we_a wa_a wd_a we_b wa_b wd_b rdy pend haz
    vecs.push_back('{1'b1,5'd3,DB,       1'b0,5'd0,32'h0,   1'b1,5'd5, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd5,5'd0,
                     1'b1,5'd3,DB,       1'b0,5'd0,32'h0,   1'b1,P5,1'b1});
    vecs.push_back('{1'b0,5'd5,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd0,32'h0,   1'b1,P5,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b1,5'd5,32'h55,  1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd0,32'h0,   1'b1,P5,1'b1});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b1,5'd5,32'h1234,  5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd5,32'h55,  1'b1,P5,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd5,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd5,32'h55,  1'b1,P5,1'b1});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd5,
                     1'b0,5'd3,DB,       1'b1,5'd5,32'h1234,1'b1,P5,1'b1});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd5,
                     1'b0,5'd3,DB,       1'b0,5'd5,32'h1234,1'b1,32'h0,1'b0});
    // FIFO fill while EX-B holds W2 for four cycles
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b1,5'd10,32'hA0, 1'b0,5'd0, 1'b1,5'd11,32'hB1,   5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd5,32'h1234,1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b1,5'd12,32'hA1, 1'b0,5'd0, 1'b1,5'd13,32'hB3,   5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd10,32'hA0, 1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b1,5'd14,32'hA2, 1'b0,5'd0, 1'b1,5'd15,32'hBF,   5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd12,32'hA1, 1'b0,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b1,5'd16,32'hA3, 1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd14,32'hA2, 1'b0,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd16,32'hA3, 1'b0,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd11,32'hB1, 1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b1,5'd13,32'hB3, 1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd13,32'hB3, 1'b1,32'h0,1'b0});
    // W1/W2 same-address collision, then zero-register suppression
    vecs.push_back('{1'b1,5'd9,32'h11,   1'b1,5'd9,32'h22,  1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd3,DB,       1'b0,5'd13,32'hB3, 1'b1,32'h0,1'b0});
    vecs.push_back('{1'b1,5'd0,32'h77,   1'b1,5'd0,32'h88,  1'b1,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b1,5'd9,32'h11,   1'b1,5'd9,32'h22,  1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd0,32'h77,   1'b0,5'd0,32'h88,  1'b1,32'h0,1'b0});
    vecs.push_back('{1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,   1'b0,5'd0, 1'b0,5'd0,32'h0,     5'd0,5'd0,5'd0,
                     1'b0,5'd0,32'h77,   1'b0,5'd0,32'h88,  1'b1,32'h0,1'b0});

    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      compare(i, vecs[i]);
      next_cycle();
    end

    // Load reissued to r7 in the same cycle its previous response commits: stays pending.
    drive_idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd7;
    next_cycle();
    drive_idle(); lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h70;
    @(negedge clk); chk("sw.pending_set", 64'(pending_o), 64'h80);
    next_cycle();
    drive_idle();
    next_cycle();
    drive_idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd7;
    @(negedge clk);
    chk("sw.we_b", 64'(we_b_o), 64'h1);
    chk("sw.waddr_b", 64'(waddr_b_o), 64'h7);
    chk("sw.wdata_b", 64'(wdata_b_o), 64'h70);
    next_cycle();
    drive_idle();
    @(negedge clk); chk("sw.set_wins", 64'(pending_o), 64'h80);
    next_cycle();
    drive_idle(); lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'h71;
    next_cycle();
    drive_idle();
    next_cycle();
    @(negedge clk);
    chk("sw.we_b2", 64'(we_b_o), 64'h1);
    chk("sw.wdata_b2", 64'(wdata_b_o), 64'h71);
    next_cycle();
    @(negedge clk); chk("sw.cleared", 64'(pending_o), 64'h0);
    next_cycle();

    // Asynchronous reset with two buffered responses and three pending loads.
    drive_idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd1;
    ex_b_valid_i = 1'b1; ex_b_waddr_i = 5'd20; ex_b_wdata_i = 32'hE0;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd1; lsu_wdata_i = 32'h100;
    next_cycle();
    drive_idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd2;
    ex_b_valid_i = 1'b1; ex_b_waddr_i = 5'd21; ex_b_wdata_i = 32'hE1;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 32'h200;
    next_cycle();
    drive_idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd3;
    ex_b_valid_i = 1'b1; ex_b_waddr_i = 5'd22; ex_b_wdata_i = 32'hE2;
    ex_a_valid_i = 1'b1; ex_a_waddr_i = 5'd4; ex_a_wdata_i = 32'h44;
    next_cycle();
    drive_idle(); raddr_a_i = 5'd1;
    #1;
    chk("rst.pre_pending", 64'(pending_o), 64'hE);
    chk("rst.pre_ready", 64'(lsu_ready_o), 64'h0);
    chk("rst.pre_we_a", 64'(we_a_o), 64'h1);
    chk("rst.pre_we_b", 64'(we_b_o), 64'h1);
    chk("rst.pre_hazard", 64'(hazard_o), 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.we_a", 64'(we_a_o), 64'h0);
    chk("rst.waddr_a", 64'(waddr_a_o), 64'h0);
    chk("rst.wdata_a", 64'(wdata_a_o), 64'h0);
    chk("rst.we_b", 64'(we_b_o), 64'h0);
    chk("rst.waddr_b", 64'(waddr_b_o), 64'h0);
    chk("rst.wdata_b", 64'(wdata_b_o), 64'h0);
    chk("rst.pending", 64'(pending_o), 64'h0);
    chk("rst.ready", 64'(lsu_ready_o), 64'h1);
    chk("rst.hazard", 64'(hazard_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("post_rst%0d.we_b", k), 64'(we_b_o), 64'h0);
      chk($sformatf("post_rst%0d.we_a", k), 64'(we_a_o), 64'h0);
      chk($sformatf("post_rst%0d.pending", k), 64'(pending_o), 64'h0);
      chk($sformatf("post_rst%0d.ready", k), 64'(lsu_ready_o), 64'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
